// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder / bit-scan encoder family.
//   WIDTH        : scanned vector width (power of two, >= 2)
//   IDX_W        : index width, derived from WIDTH
//   scan_state_t : bit-scan encoder controller states
package decoder_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ZERO = 2'd2
    } scan_state_t;

endpackage : decoder_pkg

// File: rtl/bitscan_encoder_32to5_lsb_index_find.sv
// Combinational lowest-set-bit finder.
//   vec    [WIDTH-1:0] in  : vector to inspect
//   idx    [IDX_W-1:0] out : index of the lowest set bit (0 when vec == 0)
//   onehot             out : exactly one bit of vec is set
//   none               out : vec is all-zero
module lsb_index_find
    import decoder_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int IDX_W_P = $clog2(WIDTH_P)
) (
    input  logic [WIDTH_P-1:0] vec,
    output logic [IDX_W_P-1:0] idx,
    output logic               onehot,
    output logic               none
);

    logic [WIDTH_P-1:0] vec_minus_one_s;
    logic [IDX_W_P-1:0] idx_s;

    // Scan from MSB down so the last hit written is the lowest set bit.
    always_comb begin
        idx_s = {IDX_W_P{1'b0}};
        for (int i = WIDTH_P - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_s = IDX_W_P'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // vec & (vec-1) clears the lowest set bit; zero result means at most one bit was set.
    always_comb begin
        vec_minus_one_s = vec - {{(WIDTH_P-1){1'b0}}, 1'b1};
        none            = (vec == {WIDTH_P{1'b0}});
        onehot          = !none && ((vec & vec_minus_one_s) == {WIDTH_P{1'b0}});
        idx             = idx_s;
    end

endmodule : lsb_index_find

// File: rtl/bitscan_encoder_32to5.sv
// Sequential bit-scan encoder: accepts a WIDTH-bit vector and emits the index of
// every set bit, lowest first, one index per output handshake. An all-zero vector
// yields a single beat flagged with out_zero.
//   clk, rst (async, active-high)
//   in_valid / in_ready / in [WIDTH-1:0]          : vector input handshake
//   out_valid / out_ready / out [IDX_W-1:0]       : index output handshake
//   out_last : final beat of the vector, out_zero : vector was all-zero
// All outputs are registers; nothing on the output side depends combinationally
// on in or out_ready.
module bitscan_encoder_32to5
    import decoder_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    localparam int IDX_W_P = $clog2(WIDTH_P)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_P-1:0] in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W_P-1:0] out,
    output logic               out_last,
    output logic               out_zero
);

    scan_state_t        state_r;
    logic [WIDTH_P-1:0] pending_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [IDX_W_P-1:0] out_r;
    logic               out_last_r;
    logic               out_zero_r;

    logic               accept_s;
    logic               beat_s;
    logic [WIDTH_P-1:0] pending_nxt_s;
    logic [IDX_W_P-1:0] nxt_idx_s;
    logic               nxt_onehot_s;
    logic               nxt_none_s;

    // Handshake qualifiers, taken from registered ready/valid only.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        beat_s   = out_valid_r && out_ready;
    end

    // Next pending vector: load on accept, drop the emitted bit on each beat.
    always_comb begin
        pending_nxt_s = pending_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    pending_nxt_s = in;
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            SCAN: begin
                if (beat_s) begin
                    pending_nxt_s = pending_r & (pending_r - {{(WIDTH_P-1){1'b0}}, 1'b1});
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            ZERO: begin
                pending_nxt_s = pending_r;
            end
            default: begin
                pending_nxt_s = {WIDTH_P{1'b0}};
            end
        endcase
    end

    // Inspect the next pending vector so the output registers are ready one cycle early.
    lsb_index_find #(
        .WIDTH_P (WIDTH_P),
        .IDX_W_P (IDX_W_P)
    ) u_find (
        .vec    (pending_nxt_s),
        .idx    (nxt_idx_s),
        .onehot (nxt_onehot_s),
        .none   (nxt_none_s)
    );

    // Controller FSM with registered handshake and beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= {WIDTH_P{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= {IDX_W_P{1'b0}};
            out_last_r  <= 1'b0;
            out_zero_r  <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= nxt_none_s ? ZERO : SCAN;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_r       <= nxt_idx_s;
                        out_last_r  <= nxt_onehot_s || nxt_none_s;
                        out_zero_r  <= nxt_none_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (beat_s && out_last_r) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_r       <= {IDX_W_P{1'b0}};
                        out_last_r  <= 1'b0;
                        out_zero_r  <= 1'b0;
                    end else if (beat_s) begin
                        out_r      <= nxt_idx_s;
                        out_last_r <= nxt_onehot_s;
                    end else begin
                        state_r <= SCAN;
                    end
                end
                ZERO: begin
                    if (beat_s) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_r       <= {IDX_W_P{1'b0}};
                        out_last_r  <= 1'b0;
                        out_zero_r  <= 1'b0;
                    end else begin
                        state_r <= ZERO;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pending_r   <= {WIDTH_P{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_r       <= {IDX_W_P{1'b0}};
                    out_last_r  <= 1'b0;
                    out_zero_r  <= 1'b0;
                end
            endcase
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        in_ready  = in_ready_r;
        out_valid = out_valid_r;
        out       = out_r;
        out_last  = out_last_r;
        out_zero  = out_zero_r;
    end

endmodule : bitscan_encoder_32to5

// File: tb/tb_bitscan_encoder_32to5.sv
// Self-checking bench for bitscan_encoder_32to5: directed corner vectors plus
// randomized vectors and backpressure, checked against a list-of-indices model.
module tb_bitscan_encoder_32to5;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        out_zero;

    int checks_cnt;
    int errors_cnt;

    bitscan_encoder_32to5 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // mode 0: out_ready always high; 1: random out_ready; 2: low for 3 cycles then high.
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_vector(input logic [31:0] vec, input int mode, output int cycles);
        int exp_q[$];
        logic zero;
        int guard;
        for (int k = 0; k < 32; k++) begin
            if (vec[k]) exp_q.push_back(k);
        end
        zero = (exp_q.size() == 0);
        if (zero) exp_q.push_back(0);

        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid  = 1'b1;
        in_vec    = vec;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cycles = 1;
        guard  = 0;
        in_valid = 1'($urandom_range(0, 1));
        in_vec   = $urandom;
        while (exp_q.size() > 0 && guard < 100) begin
            check("beat_valid", {31'd0, out_valid}, 32'd1);
            check("beat_idx", {27'd0, out_idx}, 32'(exp_q[0]));
            check("beat_last", {31'd0, out_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
            check("beat_zero", {31'd0, out_zero}, {31'd0, zero});
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (guard >= 3);
            endcase
            if (out_ready) void'(exp_q.pop_front());
            in_valid = 1'($urandom_range(0, 1));
            in_vec   = $urandom;
            @(negedge clk);
            cycles++;
            guard++;
        end
        if (guard >= 100) check("scan_timeout", 32'(exp_q.size()), 32'd0);
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        check("done_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] v;
        checks_cnt = 0;
        errors_cnt = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_vec     = 32'd0;
        out_ready  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out", {27'd0, out_idx}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_zero", {31'd0, out_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single low bit: ready returns 2 cycles after accept.
        run_vector(32'h0000_0001, 0, cyc);
        check("lsb_cycles", 32'(cyc), 32'd2);

        // One-hot round trip for every decoder output.
        for (int k = 0; k < 32; k++) begin
            v = 32'd1 << k;
            run_vector(v, 0, cyc);
            check("onehot_cycles", 32'(cyc), 32'd2);
        end

        run_vector(32'h8000_0001, 0, cyc);
        check("ends_cycles", 32'(cyc), 32'd3);

        run_vector(32'h0000_0000, 0, cyc);
        check("zero_cycles", 32'(cyc), 32'd2);
        run_vector(32'h0000_0000, 1, cyc);

        run_vector(32'hFFFF_FFFF, 0, cyc);
        check("full_cycles", 32'(cyc), 32'd33);

        run_vector(32'h0000_0014, 2, cyc);
        check("bp_cycles", 32'(cyc), 32'd6);

        // Randomized vectors of mixed density under random backpressure.
        for (int n = 0; n < 40; n++) begin
            case (n % 4)
                0:       v = $urandom;
                1:       v = $urandom & $urandom & $urandom;
                2:       v = 32'd1 << $urandom_range(0, 31);
                default: v = $urandom | $urandom;
            endcase
            run_vector(v, (n % 3 == 0) ? 0 : 1, cyc);
        end

        // Reset in the middle of a full scan abandons the vector immediately.
        in_valid  = 1'b1;
        in_vec    = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vector(32'h0000_0100, 0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_bitscan_encoder_32to5
